// File: rtl/rab_cfg_pkg.sv
// ---------------------------------------------------------------------------
// rab_cfg_pkg
// Shared types and constants for the RAB slice configuration register block.
//   - Address map: slice index in addr[11:5] (32-byte stride per slice),
//     word offset in addr[4:2].
//   - AXI-Lite request/response structs used on the host configuration port.
//   - slice_t: one decoded slice as seen by the translation logic.
//   - Helpers for byte-strobe merging and per-word readback.
// ---------------------------------------------------------------------------
package rab_cfg_pkg;

  localparam int unsigned SLICE_STRIDE = 32'h20;
  localparam int unsigned IDX_LSB      = 5;
  localparam int unsigned IDX_W        = 7;

  localparam logic [2:0] WORD_FIRST_LO = 3'd0;
  localparam logic [2:0] WORD_FIRST_HI = 3'd1;
  localparam logic [2:0] WORD_LAST_LO  = 3'd2;
  localparam logic [2:0] WORD_LAST_HI  = 3'd3;
  localparam logic [2:0] WORD_BASE_LO  = 3'd4;
  localparam logic [2:0] WORD_BASE_HI  = 3'd5;
  localparam logic [2:0] WORD_FLAGS    = 3'd6;
  localparam logic [2:0] WORD_RSVD     = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [63:0] first;
    logic [63:0] last;
    logic [63:0] base;
    logic        en;
    logic        rd_en;
    logic        wr_en;
  } slice_t;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } axil_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } axil_resp_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // 32-bit view of one register word of a slice. Hi words are stored
  // already masked to the address width, so they can be returned directly.
  function automatic logic [31:0] slice_word(input slice_t     s,
                                             input logic [2:0] off);
    logic [31:0] res;
    res = 32'h0;
    case (off)
      WORD_FIRST_LO: res = s.first[31:0];
      WORD_FIRST_HI: res = s.first[63:32];
      WORD_LAST_LO:  res = s.last[31:0];
      WORD_LAST_HI:  res = s.last[63:32];
      WORD_BASE_LO:  res = s.base[31:0];
      WORD_BASE_HI:  res = s.base[63:32];
      WORD_FLAGS:    res = {29'h0, s.wr_en, s.rd_en, s.en};
      default:       res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rab_cfg_axil_chan.sv
// ---------------------------------------------------------------------------
// rab_cfg_axil_chan
// Response-holding register for one AXI-Lite response channel (B or R).
// A load captures the payload and raises valid; valid and payload then stay
// stable until the consumer's ready is seen.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   load_i         capture data_i and raise valid
//   data_i         response payload to hold
//   ready_i        consumer ready; clears valid on handshake
//   valid_o        response valid
//   data_o         held payload
// ---------------------------------------------------------------------------
module rab_cfg_axil_chan #(
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // The owner only loads while the channel is empty, so load has priority
  // and the handshake simply drops valid once the consumer takes the beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rab_cfg_regs.sv
// ---------------------------------------------------------------------------
// rab_cfg_regs
// AXI-Lite responder holding the RAB slice table. Each slice occupies 0x20
// bytes: first/last/base as lo/hi 32-bit words plus a flags word
// {wr_en, rd_en, en}. Out-of-range slice indices answer DECERR.
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   cfg_req_i      AXI-Lite request from the host
//   cfg_resp_o     AXI-Lite response to the host
//   slice_o        registered slice table, one entry per slice
//   cfg_changed_o  one-cycle pulse for every write that changed state
// Build option:
//   RAB_CFG_RANGE_CHECK_EN  when defined, a flags write that sets en while
//                           first > last is refused with SLVERR.
// ---------------------------------------------------------------------------
import rab_cfg_pkg::*;

module rab_cfg_regs #(
  parameter int unsigned N_SLICES = 16,
  parameter int unsigned AXI_AW   = 64,
  parameter type axi_lite_req_t   = axil_req_t,
  parameter type axi_lite_resp_t  = axil_resp_t
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  axi_lite_req_t  cfg_req_i,
  output axi_lite_resp_t cfg_resp_o,
  output slice_t         slice_o [N_SLICES],
  output logic           cfg_changed_o
);

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  localparam logic [63:0]    HI_MASK64  = (64'd1 << (AXI_AW - 32)) - 64'd1;
  localparam logic [31:0]    HI_MASK    = HI_MASK64[31:0];
  localparam int unsigned    N_SLICES_I = N_SLICES;
  localparam logic [IDX_W:0] N_SLICES_W = N_SLICES_I[IDX_W:0];

  w_state_e    w_state_q;
  r_state_e    r_state_q;
  logic        out_en_q;
  logic        aw_held_q, w_held_q;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        cfg_changed_q;
  slice_t      slices_q [N_SLICES];

  logic             aw_ready, w_ready, ar_ready;
  logic             aw_hs, w_hs, ar_hs, commit;
  logic [31:0]      wr_addr, wr_data, wr_old, wr_new;
  logic [3:0]       wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [2:0]       wr_off, rd_off;
  logic             wr_hit, rd_hit, range_bad, wr_apply;
  logic [1:0]       wr_resp, rd_resp;
  logic [31:0]      rd_data;
  slice_t           wr_slice, rd_slice;
  logic             b_valid, r_valid;
  logic [1:0]       b_resp_q;
  logic [33:0]      r_hold_q;
  logic             unused_addr_bits;

  // Readies come from registered state only; out_en_q keeps every ready low
  // for the cycle that follows a reset edge.
  assign aw_ready = out_en_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign w_ready  = out_en_q && (w_state_q == W_IDLE) && !w_held_q;
  assign ar_ready = out_en_q && (r_state_q == R_IDLE);

  assign aw_hs = cfg_req_i.aw_valid && aw_ready;
  assign w_hs  = cfg_req_i.w_valid  && w_ready;
  assign ar_hs = cfg_req_i.ar_valid && ar_ready;

  // A beat handshaking this cycle counts as held, so AW+W arriving together
  // commit on the very next edge instead of waiting a cycle in the latches.
  assign wr_addr = aw_held_q ? aw_addr_q : cfg_req_i.aw_addr;
  assign wr_data = w_held_q  ? w_data_q  : cfg_req_i.w_data;
  assign wr_strb = w_held_q  ? w_strb_q  : cfg_req_i.w_strb;
  assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_idx = wr_addr[IDX_LSB +: IDX_W];
  assign wr_off = wr_addr[4:2];
  assign wr_hit = {1'b0, wr_idx} < N_SLICES_W;
  assign rd_idx = cfg_req_i.ar_addr[IDX_LSB +: IDX_W];
  assign rd_off = cfg_req_i.ar_addr[4:2];
  assign rd_hit = {1'b0, rd_idx} < N_SLICES_W;

  assign unused_addr_bits = ^{wr_addr[31:12], wr_addr[1:0],
                              cfg_req_i.ar_addr[31:12], cfg_req_i.ar_addr[1:0]};

  // Select the addressed slice for each path with a compare loop so that
  // the 7-bit index never has to match the array's own index width.
  always_comb begin
    wr_slice = '0;
    rd_slice = '0;
    for (int i = 0; i < N_SLICES; i++) begin
      if (wr_idx == IDX_W'(i)) wr_slice = slices_q[i];
      if (rd_idx == IDX_W'(i)) rd_slice = slices_q[i];
    end
  end

  assign wr_old = slice_word(wr_slice, wr_off);
  assign wr_new = merge_strb(wr_old, wr_data, wr_strb);

`ifdef RAB_CFG_RANGE_CHECK_EN
  assign range_bad = (wr_off == WORD_FLAGS) && wr_new[0] && (wr_slice.first > wr_slice.last);
`else
  assign range_bad = 1'b0;
`endif

  assign wr_resp  = !wr_hit ? RESP_DECERR : (range_bad ? RESP_SLVERR : RESP_OKAY);
  assign wr_apply = commit && wr_hit && !range_bad && (wr_off != WORD_RSVD);

  // Reads sample the table before any same-cycle write lands.
  assign rd_data = rd_hit ? slice_word(rd_slice, rd_off) : 32'h0;
  assign rd_resp = rd_hit ? RESP_OKAY : RESP_DECERR;

  // Ready enable: low in reset and for the first cycle afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) out_en_q <= 1'b0;
    else         out_en_q <= 1'b1;
  end

  // Write FSM: collect AW and W in any order while idle, commit once both
  // are present, then wait in W_RESP for the B handshake. The change pulse
  // is registered alongside so it lines up with b_valid rising.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q     <= W_IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      aw_addr_q     <= 32'h0;
      w_data_q      <= 32'h0;
      w_strb_q      <= 4'h0;
      cfg_changed_q <= 1'b0;
    end else begin
      cfg_changed_q <= wr_apply;
      case (w_state_q)
        W_IDLE: begin
          if (commit) begin
            w_state_q <= W_RESP;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              aw_addr_q <= cfg_req_i.aw_addr;
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              w_data_q <= cfg_req_i.w_data;
              w_strb_q <= cfg_req_i.w_strb;
            end
          end
        end
        W_RESP: begin
          if (cfg_req_i.b_ready) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Slice table update. Hi words keep only the bits that exist in the
  // configured address width, so unused bits always read back as zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_SLICES; i++) slices_q[i] <= '0;
    end else if (wr_apply) begin
      for (int i = 0; i < N_SLICES; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          case (wr_off)
            WORD_FIRST_LO: slices_q[i].first[31:0]  <= wr_new;
            WORD_FIRST_HI: slices_q[i].first[63:32] <= wr_new & HI_MASK;
            WORD_LAST_LO:  slices_q[i].last[31:0]   <= wr_new;
            WORD_LAST_HI:  slices_q[i].last[63:32]  <= wr_new & HI_MASK;
            WORD_BASE_LO:  slices_q[i].base[31:0]   <= wr_new;
            WORD_BASE_HI:  slices_q[i].base[63:32]  <= wr_new & HI_MASK;
            WORD_FLAGS: begin
              slices_q[i].en    <= wr_new[0];
              slices_q[i].rd_en <= wr_new[1];
              slices_q[i].wr_en <= wr_new[2];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read FSM: one outstanding read; the R holding register owns the data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
    end else begin
      case (r_state_q)
        R_IDLE:  if (ar_hs) r_state_q <= R_RESP;
        R_RESP:  if (cfg_req_i.r_ready) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  rab_cfg_axil_chan #(.DATA_W(2)) u_b_chan (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (commit),
    .data_i  (wr_resp),
    .ready_i (cfg_req_i.b_ready),
    .valid_o (b_valid),
    .data_o  (b_resp_q)
  );

  rab_cfg_axil_chan #(.DATA_W(34)) u_r_chan (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (ar_hs),
    .data_i  ({rd_data, rd_resp}),
    .ready_i (cfg_req_i.r_ready),
    .valid_o (r_valid),
    .data_o  (r_hold_q)
  );

  // Pack the response struct from the registered channel state.
  always_comb begin
    cfg_resp_o          = '0;
    cfg_resp_o.aw_ready = aw_ready;
    cfg_resp_o.w_ready  = w_ready;
    cfg_resp_o.b_valid  = b_valid;
    cfg_resp_o.b_resp   = b_resp_q;
    cfg_resp_o.ar_ready = ar_ready;
    cfg_resp_o.r_valid  = r_valid;
    cfg_resp_o.r_data   = r_hold_q[33:2];
    cfg_resp_o.r_resp   = r_hold_q[1:0];
  end

  assign slice_o       = slices_q;
  assign cfg_changed_o = cfg_changed_q;

endmodule

// File: tb/tb_rab_cfg_regs.sv
// ---------------------------------------------------------------------------
// tb_rab_cfg_regs
// Directed bench for rab_cfg_regs. Stimulus pushes the expected B/R response
// into a queue; a monitor pops and compares on every B/R handshake.
// ---------------------------------------------------------------------------
import rab_cfg_pkg::*;

module tb_rab_cfg_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  axil_req_t  req;
  axil_resp_t resp;
  slice_t     slices [16];
  logic       cfg_changed;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;

  logic [1:0]  b_exp_q [$];
  logic [33:0] r_exp_q [$];

  logic [31:0] t2_addr [7] = '{32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'h94, 32'h98};
  logic [31:0] t2_data [7] = '{32'h0000_1000, 32'h1, 32'hFFFF_F000, 32'h1,
                               32'h1B80_1000, 32'h0, 32'h7};

  always #5 clk = ~clk;

  rab_cfg_regs #(.N_SLICES(16), .AXI_AW(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_req_i     (req),
    .cfg_resp_o    (resp),
    .slice_o       (slices),
    .cfg_changed_o (cfg_changed)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every B/R beat the moment its handshake is set up.
  initial begin
    logic [1:0]  be;
    logic [33:0] re;
    forever begin
      @(negedge clk);
      if (rst_n && resp.b_valid && req.b_ready) begin
        if (b_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_b: got resp 0x%0h, expected no response", resp.b_resp);
        end else begin
          be = b_exp_q.pop_front();
          checkOutput("b_resp", 64'(resp.b_resp), 64'(be));
        end
      end
      if (rst_n && resp.r_valid && req.r_ready) begin
        if (r_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_r: got data 0x%0h, expected no response", resp.r_data);
        end else begin
          re = r_exp_q.pop_front();
          checkOutput("r_data", 64'(resp.r_data), 64'(re[33:2]));
          checkOutput("r_resp", 64'(resp.r_resp), 64'(re[1:0]));
        end
      end
      if (rst_n && cfg_changed) chg_cnt++;
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 100; i++) begin
      if (b_exp_q.size() == 0 && r_exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (b_exp_q.size() != 0 || r_exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d B and %0d R pending, expected 0",
               b_exp_q.size(), r_exp_q.size());
      b_exp_q.delete();
      r_exp_q.delete();
    end
  endtask

  // One complete write (AW and W together) or read, then wait for the reply.
  task automatic applyStimulus(input bit is_wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [1:0] exp_resp, input logic [31:0] exp_data);
    bit a_done, d_done, a_acc, d_acc;
    @(posedge clk); #1;
    if (is_wr) begin
      b_exp_q.push_back(exp_resp);
      req.aw_addr = addr; req.aw_valid = 1'b1;
      req.w_data = data;  req.w_strb = strb; req.w_valid = 1'b1;
      a_done = 0; d_done = 0;
      for (int i = 0; i < 50 && !(a_done && d_done); i++) begin
        @(negedge clk);
        a_acc = resp.aw_ready; d_acc = resp.w_ready;
        @(posedge clk); #1;
        if (a_acc && req.aw_valid) begin req.aw_valid = 1'b0; a_done = 1; end
        if (d_acc && req.w_valid)  begin req.w_valid  = 1'b0; d_done = 1; end
      end
      if (!(a_done && d_done)) begin
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        n_checks++; n_fail++;
        $display("[TB] FAIL write_accept_timeout: got no AW/W handshake, expected one at 0x%0h", addr);
      end
    end else begin
      r_exp_q.push_back({exp_data, exp_resp});
      req.ar_addr = addr; req.ar_valid = 1'b1;
      a_done = 0;
      for (int i = 0; i < 50 && !a_done; i++) begin
        @(negedge clk);
        a_acc = resp.ar_ready;
        @(posedge clk); #1;
        if (a_acc) begin req.ar_valid = 1'b0; a_done = 1; end
      end
      if (!a_done) begin
        req.ar_valid = 1'b0;
        n_checks++; n_fail++;
        $display("[TB] FAIL read_accept_timeout: got no AR handshake, expected one at 0x%0h", addr);
      end
    end
    waitDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int chg_before;
    rst_n = 1'b0;
    req = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("aw_ready_in_reset", 64'(resp.aw_ready), 64'd0);
    checkOutput("ar_ready_in_reset", 64'(resp.ar_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("aw_ready_rst", 64'(resp.aw_ready), 64'd1);
    checkOutput("w_ready_rst",  64'(resp.w_ready),  64'd1);
    checkOutput("ar_ready_rst", 64'(resp.ar_ready), 64'd1);
    checkOutput("b_valid_rst",  64'(resp.b_valid),  64'd0);
    checkOutput("r_valid_rst",  64'(resp.r_valid),  64'd0);
    checkOutput("s4_first_rst", slices[4].first, 64'd0);
    checkOutput("s4_last_rst",  slices[4].last,  64'd0);
    checkOutput("s4_base_rst",  slices[4].base,  64'd0);
    checkOutput("s4_flags_rst", 64'({slices[4].wr_en, slices[4].rd_en, slices[4].en}), 64'd0);

    // Program slice 4 and read everything back.
    for (int i = 0; i < 7; i++) applyStimulus(1, t2_addr[i], t2_data[i], 4'hF, RESP_OKAY, 32'h0);
    checkOutput("s4_first", slices[4].first, 64'h1_0000_1000);
    checkOutput("s4_last",  slices[4].last,  64'h1_FFFF_F000);
    checkOutput("s4_base",  slices[4].base,  64'h0_1B80_1000);
    checkOutput("s4_flags", 64'({slices[4].wr_en, slices[4].rd_en, slices[4].en}), 64'd7);
    checkOutput("chg_pulses", 64'(chg_cnt), 64'd7);
    for (int i = 0; i < 7; i++) applyStimulus(0, t2_addr[i], 32'h0, 4'h0, RESP_OKAY, t2_data[i]);

    // W three cycles ahead of AW, partial strobe, B held off for 5 cycles.
    req.b_ready = 1'b0;
    b_exp_q.push_back(RESP_OKAY);
    @(posedge clk); #1;
    req.w_data = 32'hDEAD_BEEF; req.w_strb = 4'b0011; req.w_valid = 1'b1;
    @(negedge clk);
    checkOutput("w_ready_idle", 64'(resp.w_ready), 64'd1);
    @(posedge clk); #1;
    req.w_valid = 1'b0;
    checkOutput("w_ready_held",  64'(resp.w_ready),  64'd0);
    checkOutput("aw_ready_open", 64'(resp.aw_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    req.aw_addr = 32'h10; req.aw_valid = 1'b1;
    @(negedge clk);
    checkOutput("b_valid_before_aw", 64'(resp.b_valid), 64'd0);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    checkOutput("b_latency", 64'(resp.b_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("b_valid_hold", 64'(resp.b_valid), 64'd1);
      checkOutput("b_resp_hold",  64'(resp.b_resp),  64'(RESP_OKAY));
      checkOutput("aw_w_ready_hold", 64'({resp.aw_ready, resp.w_ready}), 64'd0);
    end
    req.b_ready = 1'b1;
    waitDrain();
    checkOutput("s0_base_strb", slices[0].base, 64'h0000_BEEF);

    // Read held off for 5 cycles.
    req.r_ready = 1'b0;
    r_exp_q.push_back({32'h1B80_1000, RESP_OKAY});
    @(posedge clk); #1;
    req.ar_addr = 32'h90; req.ar_valid = 1'b1;
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("r_valid_hold", 64'(resp.r_valid), 64'd1);
      checkOutput("r_data_hold",  64'(resp.r_data),  64'h1B80_1000);
      checkOutput("ar_ready_hold", 64'(resp.ar_ready), 64'd0);
    end
    req.r_ready = 1'b1;
    waitDrain();

    // Out-of-range index and reserved word.
    chg_before = chg_cnt;
    applyStimulus(1, 32'h200, 32'hFFFF_FFFF, 4'hF, RESP_DECERR, 32'h0);
    checkOutput("decerr_no_change_s0", slices[0].first, 64'd0);
    checkOutput("decerr_no_pulse", 64'(chg_cnt), 64'(chg_before));
    applyStimulus(0, 32'h200, 32'h0, 4'h0, RESP_DECERR, 32'h0);
    applyStimulus(0, 32'h1C,  32'h0, 4'h0, RESP_OKAY,   32'h0);

    // Enabling a slice whose first is above its last.
    applyStimulus(1, 32'h20, 32'h2000, 4'hF, RESP_OKAY, 32'h0);
    applyStimulus(1, 32'h28, 32'h1000, 4'hF, RESP_OKAY, 32'h0);
`ifdef RAB_CFG_RANGE_CHECK_EN
    applyStimulus(1, 32'h38, 32'h1, 4'hF, RESP_SLVERR, 32'h0);
    checkOutput("s1_en_rejected", 64'(slices[1].en), 64'd0);
`else
    applyStimulus(1, 32'h38, 32'h1, 4'hF, RESP_OKAY, 32'h0);
    checkOutput("s1_en_accepted", 64'(slices[1].en), 64'd1);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
